// File: rtl/iop_pkg.sv
// Shared function codes, condition codes and FSM encoding for the IOP channel scheduler.
package iop_pkg;

  localparam logic [2:0] FNC_SIO = 3'd0;
  localparam logic [2:0] FNC_TIO = 3'd1;
  localparam logic [2:0] FNC_TDV = 3'd2;
  localparam logic [2:0] FNC_HIO = 3'd3;
  localparam logic [2:0] FNC_AIO = 3'd6;

  localparam logic [1:0] CC_OK    = 2'd0;
  localparam logic [1:0] CC_BUSY  = 2'd1;
  localparam logic [1:0] CC_NODEV = 2'd3;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StDecode  = 2'd1,
    StRespond = 2'd2,
    StWait    = 2'd3
  } iop_state_e;

endpackage

// File: rtl/iop_rr_arbiter.sv
// Round-robin arbiter for the shared memory port: registered one-hot grant, held until the
// owner drops its request, pointer advances past the released owner.
module iop_rr_arbiter #(
  parameter int unsigned NUM_DEV = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [0:NUM_DEV-1] req,
  output logic [0:NUM_DEV-1] gnt,
  output logic [2:0]         owner
);

  logic [0:NUM_DEV-1] gnt_q, gnt_d;
  logic [2:0]         owner_q, owner_d;
  logic [2:0]         ptr_q, ptr_d;
  logic               found;

  // Next grant: hold while owner requests, release for one idle cycle, else pick from pointer.
  always_comb begin
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    found   = 1'b0;
    if (|gnt_q) begin
      if (!(|(gnt_q & req))) begin
        gnt_d   = '0;
        owner_d = '0;
        ptr_d   = (owner_q == 3'(NUM_DEV - 1)) ? 3'd0 : owner_q + 3'd1;
      end
    end else begin
      // First pass: requesters at or after the pointer.
      for (int unsigned i = 0; i < NUM_DEV; i++) begin
        if (!found && req[i] && (3'(i) >= ptr_q)) begin
          found      = 1'b1;
          gnt_d[i]   = 1'b1;
          owner_d    = 3'(i);
        end
      end
      // Wrap-around pass: only reached when nothing at or after the pointer requests.
      for (int unsigned i = 0; i < NUM_DEV; i++) begin
        if (!found && req[i]) begin
          found      = 1'b1;
          gnt_d[i]   = 1'b1;
          owner_d    = 3'(i);
        end
      end
    end
  end

  // Grant, owner and pointer registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;

endmodule

// File: rtl/iop_channel_scheduler.sv
// Sequences CPU I/O instructions onto device-controller slots, tracks interrupt-pending flags
// and arbitrates the shared memory port among the slots.
module iop_channel_scheduler
  import iop_pkg::*;
#(
  parameter int unsigned            NUM_DEV = 4,
  parameter int unsigned            IOP_NUM = 0,
  parameter logic [8*NUM_DEV-1:0]   DEV_MAP = 32'h01020305
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cpu_req,
  input  logic [0:2]         iop_func,
  input  logic [21:31]       iop_device,
  output logic               cpu_ack,
  output logic [0:1]         iop_cc,
  output logic [0:7]         aio_device,
  output logic [0:NUM_DEV-1] dev_start,
  output logic [0:NUM_DEV-1] dev_halt,
  input  logic [0:NUM_DEV-1] dev_busy,
  input  logic [0:NUM_DEV-1] dev_mem_req,
  output logic [0:NUM_DEV-1] dev_mem_gnt,
  output logic [0:2]         mem_owner
);

  iop_state_e         state_q, state_d;
  logic [2:0]         func_q;
  logic [21:31]       dev_q;
  logic [0:NUM_DEV-1] busy_prev_q, pending_q, pending_d, pend_clr;
  logic               ack_q, ack_d;
  logic [1:0]         cc_q, cc_d;
  logic [7:0]         aio_q, aio_d;
  logic [0:NUM_DEV-1] start_q, start_d, halt_q, halt_d;

  logic               hit, hit_busy, iop_ok, pend_found;
  logic [0:NUM_DEV-1] hit_oh, pend_oh;
  logic [7:0]         pend_addr;

  // Slot lookup for the latched device and lowest pending slot for AIO.
  always_comb begin
    hit        = 1'b0;
    hit_oh     = '0;
    hit_busy   = 1'b0;
    pend_found = 1'b0;
    pend_oh    = '0;
    pend_addr  = '0;
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      if (!hit && (dev_q[24:31] == DEV_MAP[8*(NUM_DEV-1-i) +: 8])) begin
        hit       = 1'b1;
        hit_oh[i] = 1'b1;
        hit_busy  = dev_busy[i];
      end
      if (!pend_found && pending_q[i]) begin
        pend_found = 1'b1;
        pend_oh[i] = 1'b1;
        pend_addr  = DEV_MAP[8*(NUM_DEV-1-i) +: 8];
      end
    end
    iop_ok = (dev_q[21:23] == 3'(IOP_NUM));
  end

  // Request FSM; the reply and strobes are registered out of DECODE so they show in RESPOND.
  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    cc_d     = CC_OK;
    aio_d    = '0;
    start_d  = '0;
    halt_d   = '0;
    pend_clr = '0;
    case (state_q)
      StIdle: begin
        if (cpu_req) state_d = StDecode;
      end
      StDecode: begin
        state_d = StRespond;
        ack_d   = 1'b1;
        if (func_q == FNC_AIO) begin
          if (pend_found) begin
            aio_d    = pend_addr;
            pend_clr = pend_oh;
          end else begin
            cc_d = CC_NODEV;
          end
        end else if (!(hit && iop_ok)) begin
          cc_d = CC_NODEV;
        end else begin
          case (func_q)
            FNC_SIO: begin
              if (hit_busy) cc_d = CC_BUSY;
              else          start_d = hit_oh;
            end
            FNC_TIO, FNC_TDV: cc_d = hit_busy ? CC_BUSY : CC_OK;
            FNC_HIO: begin
              cc_d   = hit_busy ? CC_BUSY : CC_OK;
              halt_d = hit_oh;
            end
            default: cc_d = CC_NODEV;
          endcase
        end
      end
      StRespond: state_d = StWait;
      StWait: begin
        if (!cpu_req) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A busy 1->0 edge raises pending; it overrides an AIO clear of the same slot.
  always_comb begin
    pending_d = (pending_q & ~pend_clr) | (busy_prev_q & ~dev_busy);
  end

  // State, request latch, pending flags and registered replies.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= StIdle;
      func_q      <= '0;
      dev_q       <= '0;
      busy_prev_q <= '0;
      pending_q   <= '0;
      ack_q       <= 1'b0;
      cc_q        <= '0;
      aio_q       <= '0;
      start_q     <= '0;
      halt_q      <= '0;
    end else begin
      state_q     <= state_d;
      if (state_q == StIdle && cpu_req) begin
        func_q <= iop_func;
        dev_q  <= iop_device;
      end
      busy_prev_q <= dev_busy;
      pending_q   <= pending_d;
      ack_q       <= ack_d;
      cc_q        <= cc_d;
      aio_q       <= aio_d;
      start_q     <= start_d;
      halt_q      <= halt_d;
    end
  end

  assign cpu_ack    = ack_q;
  assign iop_cc     = cc_q;
  assign aio_device = aio_q;
  assign dev_start  = start_q;
  assign dev_halt   = halt_q;

  iop_rr_arbiter #(
    .NUM_DEV(NUM_DEV)
  ) u_arb (
    .clock(clock),
    .reset(reset),
    .req  (dev_mem_req),
    .gnt  (dev_mem_gnt),
    .owner(mem_owner)
  );

endmodule

// File: doc/iop_channel_scheduler.md
Name: iop_channel_scheduler

Overview:
Sequences CPU I/O instructions (SIO/TIO/TDV/HIO/AIO) onto up to NUM_DEV device-controller slots behind one IOP. Owns the device start/halt strobes, per-slot interrupt-pending flags and the condition-code reply. Round-robin arbitrates the single shared memory port among slot controllers. Sits between the CPU I/O decode and the console/papertape-style device controllers.

Parameters:
NUM_DEV, 4, number of device-controller slots (1..8)
IOP_NUM, 0, IOP number matched against iop_device[21:23]
DEV_MAP, 32'h01020305, packed 8-bit device addresses, slot 0 in bits [8*NUM_DEV-1 -: 8]

Ports:
clock  in  1  single system clock, all state on posedge
reset  in  1  synchronous, active-low; state clears on a posedge clock with reset==0
cpu_req  in  1  CPU I/O request, held until cpu_ack
iop_func  in  [0:2]  0 SIO, 1 TIO, 2 TDV, 3 HIO, 6 AIO
iop_device  in  [21:31]  [21:23] IOP number, [24:31] device address
cpu_ack  out  1  one-cycle completion pulse
iop_cc  out  [0:1]  condition code, valid only while cpu_ack==1
aio_device  out  [0:7]  device address reported by AIO, valid with cpu_ack
dev_start  out  [0:NUM_DEV-1]  one-cycle start pulse per slot
dev_halt  out  [0:NUM_DEV-1]  one-cycle halt pulse per slot
dev_busy  in  [0:NUM_DEV-1]  slot controller active
dev_mem_req  in  [0:NUM_DEV-1]  slot wants memory port
dev_mem_gnt  out  [0:NUM_DEV-1]  one-hot or zero grant
mem_owner  out  [0:2]  index of granted slot, 0 when none

Behaviour:
- Reset: cpu_ack=0, iop_cc=0, aio_device=0, dev_start=0, dev_halt=0, dev_mem_gnt=0, mem_owner=0, pending=0, rr pointer=0, FSM=IDLE.
- FSM IDLE -> DECODE when cpu_req=1; latch func/device. DECODE -> RESPOND; compute hit slot = first slot with DEV_MAP match and iop_device[21:23]==IOP_NUM. RESPOND: cpu_ack=1 for one cycle, strobes issued that cycle, -> WAIT. WAIT -> IDLE once cpu_req=0; no re-trigger while req stays high. Ack latency: exactly 2 cycles after req sampled.
- No hit, or unknown func (4,5,7): cc=3, no strobe.
- SIO: busy -> cc=1, no strobe; idle -> cc=0, dev_start[slot] pulse.
- TIO/TDV: cc=0 idle, cc=1 busy; no strobe.
- HIO: cc=1 if slot was busy else 0; dev_halt[slot] pulse regardless.
- AIO: device field ignored; lowest-index pending slot reported in aio_device, its pending bit cleared, cc=0; none pending -> cc=3, aio_device=0.
- Pending: set on dev_busy 1->0 (registered prev value). Set and AIO-clear on same bit same cycle -> set wins.
- Memory arbiter independent of FSM: grant registered; when no grant, next cycle grants first requester at or after rr pointer (wrapping); grant held while that req stays high; on release grant drops next cycle, rr pointer = owner+1 mod NUM_DEV, new grant no earlier than following cycle. Request dropping for an unowned slot: ignored.
- HIO to memory owner does not revoke grant; the controller must drop req.
- Reset mid-transaction: all cleared immediately, an in-flight cpu_req is re-served from IDLE after reset release.

Decomposition:
- Shared package iop_pkg: FNC_SIO/TIO/TDV/HIO/AIO, CC_OK=0, CC_BUSY=1, CC_NODEV=3, FSM state encodings.
- Sub-module iop_rr_arbiter (NUM_DEV req -> one-hot gnt, hold-until-release, rotating pointer).

Test Plan:
- SIO to device 0x05, slot 3 idle -> ack at req+2, cc=0, dev_start=0001 for one cycle; repeat while dev_busy[3]=1 -> cc=1, no start.
- TIO to device 0x07 and TIO with iop_device[21:23]=1 -> cc=3, no strobes; func=5 -> cc=3.
- dev_busy[1] and [3] fall -> AIO returns 0x02 cc=0, AIO returns 0x05 cc=0, third AIO cc=3 aio_device=0.
- dev_mem_req=1111 held 3 cycles each then released -> grants 1000,0100,0010,0001 in order, one idle cycle between, never two bits set.
- HIO to busy slot 0 -> cc=1, dev_halt=1000 pulse; owner grant unchanged until req drops.
- reset low during DECODE with cpu_req high -> no ack; after release SIO completes with ack 2 cycles later, pending flags zero.
